icache_resp: RTL and testbench



---
 rtl/icache_resp.sv | 130 +++++++++++++
 tb/tb_icache_resp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache responder: flop-based tag/valid/data arrays,
// single-line refill FSM, frontend flush and whole-cache invalidate.
module icache_resp #(
  parameter int unsigned ADDR       = 32,
  parameter int unsigned INST       = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_e_,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            flush_,
  input  logic            ic_inv,
  output logic            ic_stall,
  output logic            ic_inst_v,
  output logic [INST-1:0] ic_inst,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(INST / 8);
  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR - OFF_W - WORD_W - IDX_W;
  localparam logic [ADDR-1:0] LINE_MASK = ADDR'((64'd1 << (OFF_W + WORD_W)) - 64'd1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StFill, StResp} state_e;

  state_e              r_state, w_state_nxt;
  logic                r_lk_v;
  logic [ADDR-1:0]     r_lk_pc;
  logic [SETS-1:0]     r_valid;
  logic [TAG_W-1:0]    r_tag  [SETS];
  logic [INST-1:0]     r_data [SETS][LINE_WORDS];
  logic [WORD_W-1:0]   r_cnt;
  logic                r_drop;
  logic                r_inv_pend;
  logic                r_mem_req;
  logic [ADDR-1:0]     r_mem_addr;

  logic [IDX_W-1:0]    w_idx;
  logic [WORD_W-1:0]   w_word;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit, w_lookup, w_miss, w_accept, w_beat, w_last, w_busy;

  assign w_word   = r_lk_pc[OFF_W +: WORD_W];
  assign w_idx    = r_lk_pc[OFF_W + WORD_W +: IDX_W];
  assign w_tag    = r_lk_pc[ADDR-1 -: TAG_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lookup = (r_state == StIdle) && r_lk_v;
  // Flush and invalidate both suppress the refill a lookup miss would start.
  assign w_miss   = w_lookup && flush_ && !ic_inv && !w_hit;
  assign w_busy   = (r_state == StReq) || (r_state == StFill);
  assign w_beat   = (r_state == StFill) && mem_rvalid;
  assign w_last   = w_beat && (r_cnt == LAST_WORD);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_miss) w_state_nxt = StReq;
      StReq:   if (r_mem_req && mem_ack) w_state_nxt = StFill;
      StFill:  if (w_last) w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    ic_stall  = w_miss || w_busy;
    ic_inst_v = flush_ && ((w_lookup && !ic_inv && w_hit) || ((r_state == StResp) && !r_drop));
    ic_inst   = ic_inst_v ? r_data[w_idx][w_word] : '0;
    w_accept  = !fetch_e_ && flush_ && !ic_stall &&
                ((r_state == StIdle) || (r_state == StResp));
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_lk_v     <= 1'b0;
      r_lk_pc    <= '0;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_inv_pend <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lk_v  <= w_accept;
      if (w_accept) r_lk_pc <= fetch_pc;

      if (w_miss) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_lk_pc & ~LINE_MASK;
        r_cnt      <= '0;
      end else begin
        if ((r_state == StReq) && mem_ack) r_mem_req <= 1'b0;
        if (w_beat) r_cnt <= r_cnt + WORD_W'(1);
      end

      if (r_state == StResp) r_drop <= 1'b0;
      else if (w_busy && !flush_) r_drop <= 1'b1;

      if (r_state == StResp) r_inv_pend <= 1'b0;
      else if (w_busy && ic_inv) r_inv_pend <= 1'b1;

      // Deferred invalidate lands in RESP, after the filled line was written invalid.
      if (((r_state == StIdle) && ic_inv) ||
          ((r_state == StResp) && (ic_inv || r_inv_pend))) begin
        r_valid <= '0;
      end else if (w_last) begin
        r_valid[w_idx] <= !(r_inv_pend || ic_inv);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_data[w_idx][r_cnt] <= mem_rdata;
    if (w_last) r_tag[w_idx] <= w_tag;
  end

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: cold miss, hits, conflict, flush, invalidate, reset.
module tb_icache_resp;

  logic        clk;
  logic        reset;
  logic        fetch_e_;
  logic [31:0] fetch_pc;
  logic        flush_;
  logic        ic_inv;
  logic        ic_stall;
  logic        ic_inst_v;
  logic [31:0] ic_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  icache_resp #(
    .ADDR(32), .INST(32), .LINE_WORDS(4), .SETS(16)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_e_   (fetch_e_),
    .fetch_pc   (fetch_pc),
    .flush_     (flush_),
    .ic_inv     (ic_inv),
    .ic_stall   (ic_stall),
    .ic_inst_v  (ic_inst_v),
    .ic_inst    (ic_inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch pc that must miss, run a refill of base+0..3 (gap after beat 1, where
  // flush/invalidate may be injected) and check the RESP cycle.
  task automatic miss_fetch(input logic [31:0] pc, input logic [31:0] base, input bit fl,
                            input bit inv, input bit exp_v);
    fetch_e_ = 1'b0; fetch_pc = pc; #1;
    check("req_stall", ic_stall, 0);
    step();
    fetch_e_ = 1'b1; #1;
    check("miss_stall", ic_stall, 1);
    check("miss_inst_v", ic_inst_v, 0);
    step();
    check("req_mem_req", mem_req, 1);
    check("req_mem_addr", mem_addr, pc & 32'hFFFF_FFF0);
    check("req_stall_hold", ic_stall, 1);
    step();
    mem_ack = 1'b1; #1;
    step();
    mem_ack = 1'b0; #1;
    check("fill_mem_req", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = base + 32'(i); #1;
      check("fill_stall", ic_stall, 1);
      step();
      mem_rvalid = 1'b0;
      if (i == 1) begin
        flush_ = !fl; ic_inv = inv;
        step();
        flush_ = 1'b1; ic_inv = 1'b0;
      end
    end
    #1;
    check("resp_stall", ic_stall, 0);
    check("resp_inst_v", ic_inst_v, 32'(exp_v));
    if (exp_v) check("resp_inst", ic_inst, base + 32'(pc[3:2]));
    step();
  endtask

  task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] exp);
    fetch_e_ = 1'b0; fetch_pc = pc; #1;
    step();
    fetch_e_ = 1'b1; #1;
    check("hit_inst_v", ic_inst_v, 1);
    check("hit_inst", ic_inst, exp);
    check("hit_stall", ic_stall, 0);
    step();
  endtask

  initial begin
    reset = 1'b1; fetch_e_ = 1'b1; fetch_pc = '0; flush_ = 1'b1; ic_inv = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_stall", ic_stall, 0);
    check("rst_inst_v", ic_inst_v, 0);
    check("rst_inst", ic_inst, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    step();

    // Cold miss on 0x100
    miss_fetch(32'h100, 32'hA0, 1'b0, 1'b0, 1'b1);

    // Back-to-back hits, one result per cycle
    fetch_e_ = 1'b0; fetch_pc = 32'h104; #1;
    check("b2b_pre_v", ic_inst_v, 0);
    step();
    fetch_pc = 32'h108; #1;
    check("b2b_0_v", ic_inst_v, 1);
    check("b2b_0", ic_inst, 32'hA1);
    step();
    fetch_pc = 32'h10C; #1;
    check("b2b_1_v", ic_inst_v, 1);
    check("b2b_1", ic_inst, 32'hA2);
    step();
    fetch_e_ = 1'b1; #1;
    check("b2b_2_v", ic_inst_v, 1);
    check("b2b_2", ic_inst, 32'hA3);
    check("b2b_mem_req", mem_req, 0);
    check("b2b_stall", ic_stall, 0);
    step();
    check("b2b_end_v", ic_inst_v, 0);

    // Conflict in index 0
    miss_fetch(32'h1100, 32'hB0, 1'b0, 1'b0, 1'b1);
    miss_fetch(32'h100, 32'hA0, 1'b0, 1'b0, 1'b1);

    // Flush in the lookup cycle of a hit
    fetch_e_ = 1'b0; fetch_pc = 32'h104; #1;
    step();
    fetch_e_ = 1'b1; flush_ = 1'b0; #1;
    check("flush_lk_v", ic_inst_v, 0);
    check("flush_lk_stall", ic_stall, 0);
    step();
    flush_ = 1'b1; #1;
    check("flush_lk_mem_req", mem_req, 0);
    check("flush_lk_after_v", ic_inst_v, 0);

    // Flush mid-fill: line installed, response dropped
    miss_fetch(32'h200, 32'hC0, 1'b1, 1'b0, 1'b0);
    hit_fetch(32'h204, 32'hC1);

    // Invalidate in IDLE
    ic_inv = 1'b1; #1;
    step();
    ic_inv = 1'b0;
    miss_fetch(32'h104, 32'hA0, 1'b0, 1'b0, 1'b1);

    // Populate index 1, then invalidate during a fill of index 0
    miss_fetch(32'h110, 32'hE0, 1'b0, 1'b0, 1'b1);
    hit_fetch(32'h114, 32'hE1);
    miss_fetch(32'h300, 32'hD0, 1'b0, 1'b1, 1'b1);
    miss_fetch(32'h300, 32'hF0, 1'b0, 1'b0, 1'b1);
    miss_fetch(32'h100, 32'hA0, 1'b0, 1'b0, 1'b1);
    miss_fetch(32'h114, 32'hE0, 1'b0, 1'b0, 1'b1);

    // Request presented with flush_ low is not registered
    fetch_e_ = 1'b0; fetch_pc = 32'h114; flush_ = 1'b0; #1;
    step();
    fetch_e_ = 1'b1; flush_ = 1'b1; #1;
    check("flush_req_v", ic_inst_v, 0);
    step();

    // Reset mid-refill abandons it; stray beats are ignored
    fetch_e_ = 1'b0; fetch_pc = 32'h400; #1;
    step();
    fetch_e_ = 1'b1; #1;
    step();
    mem_ack = 1'b1; #1;
    step();
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    step();
    mem_rvalid = 1'b0; reset = 1'b1; #1;
    step();
    reset = 1'b0; #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_stall", ic_stall, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h66; #1;
    step(); step();
    mem_rvalid = 1'b0; #1;
    check("stray_stall", ic_stall, 0);
    check("stray_inst_v", ic_inst_v, 0);
    fetch_e_ = 1'b0; fetch_pc = 32'h104; #1;
    step();
    fetch_e_ = 1'b1; #1;
    check("post_rst_miss", ic_stall, 1);
    check("post_rst_inst_v", ic_inst_v, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
